// File: rtl/edge_pulse_pkg.sv
// Shared types and constants for the debounced edge-to-pulse front end.
package edge_pulse_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } edge_state_t;

  function automatic logic is_check(input edge_state_t st);
    return (st == CHK_HIGH) || (st == CHK_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchroniser (SYNC_STAGES deep) for an asynchronous input bus.
module sync_2ff
  import edge_pulse_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/edge_pulse_gen.sv
// Debounced edge-to-pulse generator feeding an event counter's count_enable.
// Define EDGE_PULSE_BOTH_EN to also pulse on accepted falling edges.
module edge_pulse_gen
  import edge_pulse_pkg::*;
#(
  parameter int DB_BITS     = 4,
  parameter int GLITCH_BITS = 8
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   async_in,
  input  logic                   enable,
  input  logic [DB_BITS-1:0]     db_threshold,
  output logic                   pulse_out,
  output logic                   level_out,
  output logic                   busy,
  output logic [GLITCH_BITS-1:0] glitch_cnt
);

  localparam logic [DB_BITS-1:0] DB_ONE = DB_BITS'(1);

  logic                   s2;
  logic [DB_BITS-1:0]     thr;
  logic [GLITCH_BITS-1:0] glitch_inc;

  edge_state_t            state_q,  state_d;
  logic [DB_BITS-1:0]     db_cnt_q, db_cnt_d;
  logic                   level_q,  level_d;
  logic                   pulse_q,  pulse_d;
  logic [GLITCH_BITS-1:0] glitch_q, glitch_d;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .RST (RST),
    .d_i (async_in),
    .q_o (s2)
  );

  // Threshold is read live; a zero setting behaves as one.
  assign thr        = (db_threshold == '0) ? DB_ONE : db_threshold;
  assign glitch_inc = (glitch_q == '1) ? glitch_q : glitch_q + GLITCH_BITS'(1);

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    pulse_d  = 1'b0;
    glitch_d = glitch_q;
    case (state_q)
      IDLE_LOW: begin
        if (s2) begin
          state_d  = CHK_HIGH;
          db_cnt_d = DB_ONE;
        end
      end
      CHK_HIGH: begin
        // A reversal wins over a threshold hit on the same cycle.
        if (!s2) begin
          state_d  = IDLE_LOW;
          glitch_d = glitch_inc;
        end else if (db_cnt_q >= thr) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          pulse_d = enable;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_d  = CHK_LOW;
          db_cnt_d = DB_ONE;
        end
      end
      CHK_LOW: begin
        if (s2) begin
          state_d  = IDLE_HIGH;
          glitch_d = glitch_inc;
        end else if (db_cnt_q >= thr) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
`ifdef EDGE_PULSE_BOTH_EN
          pulse_d = enable;
`else
          pulse_d = 1'b0;
`endif
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE_LOW;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      glitch_q <= glitch_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign level_out  = level_q;
  assign busy       = is_check(state_q);
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Self-checking bench for edge_pulse_gen: directed scenarios plus randomized
// run-length stimulus against a run-length model of the debounce rules.
module tb_edge_pulse_gen;

  localparam int DB_BITS     = 4;
  localparam int GLITCH_BITS = 8;
  localparam int GLITCH_MAX  = (1 << GLITCH_BITS) - 1;
`ifdef EDGE_PULSE_BOTH_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   RST = 1'b1;
  logic                   async_in = 1'b0;
  logic                   enable = 1'b0;
  logic [DB_BITS-1:0]     db_threshold = '0;
  logic                   pulse_out;
  logic                   level_out;
  logic                   busy;
  logic [GLITCH_BITS-1:0] glitch_cnt;

  edge_pulse_gen #(.DB_BITS(DB_BITS), .GLITCH_BITS(GLITCH_BITS)) dut (
    .clk          (clk),
    .RST          (RST),
    .async_in     (async_in),
    .enable       (enable),
    .db_threshold (db_threshold),
    .pulse_out    (pulse_out),
    .level_out    (level_out),
    .busy         (busy),
    .glitch_cnt   (glitch_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // observation counters for directed scenarios
  int dut_pulses, dut_pulse_edge, dut_busy_cycles;
  int mdl_pulses, mdl_pulse_edge;

  // ---------------- behavioural model ----------------
  // sync_hist holds the raw samples still travelling through the synchroniser;
  // the oldest entry is what the debouncer observes at the next edge.
  logic sync_hist[$];
  logic m_level, m_pulse, m_busy;
  int   m_run;     // consecutive observed samples disagreeing with m_level
  int   m_glitch;

  task automatic model_reset();
    sync_hist = {1'b0, 1'b0};
    m_level = 1'b0; m_pulse = 1'b0; m_busy = 1'b0;
    m_run = 0; m_glitch = 0;
  endtask

  task automatic model_step(input logic a, input logic en,
                            input logic [DB_BITS-1:0] th, input logic rst);
    logic obs;
    int   thr_eff;
    if (rst) begin
      model_reset();
      return;
    end
    obs = sync_hist.pop_front();
    sync_hist.push_back(a);
    thr_eff = (th == 0) ? 1 : int'(th);
    m_pulse = 1'b0;
    if (obs != m_level) begin
      m_run++;
      // first disagreeing sample only opens the check; each later one has
      // m_run-1 earlier confirmations behind it
      if (m_run >= 2 && (m_run - 1) >= thr_eff) begin
        m_level = obs;
        m_run   = 0;
        m_pulse = en && (obs || BOTH);
      end
    end else begin
      if (m_run > 0 && m_glitch < GLITCH_MAX) m_glitch++;
      m_run = 0;
    end
    m_busy = (m_run > 0);
    if (m_pulse) begin
      mdl_pulses++;
      mdl_pulse_edge = edge_n;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp_v);
    end
  endtask

  task automatic compare_all();
    check("pulse_out",  int'(pulse_out),  int'(m_pulse));
    check("level_out",  int'(level_out),  int'(m_level));
    check("busy",       int'(busy),       int'(m_busy));
    check("glitch_cnt", int'(glitch_cnt), m_glitch);
    if (pulse_out === 1'b1) begin
      dut_pulses++;
      dut_pulse_edge = edge_n;
    end
    if (busy === 1'b1) dut_busy_cycles++;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic a, input logic en,
                       input logic [DB_BITS-1:0] th, input logic rst);
    async_in = a; enable = en; db_threshold = th; RST = rst;
    @(posedge clk);
    edge_n++;
    model_step(a, en, th, rst);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_obs();
    dut_pulses = 0; dut_pulse_edge = -1; dut_busy_cycles = 0;
    mdl_pulses = 0; mdl_pulse_edge = -1;
  endtask

  // Reset, then number the following edges from 1.
  task automatic do_reset(input logic [DB_BITS-1:0] th);
    cycle(1'b0, 1'b1, th, 1'b1);
    edge_n = 0;
    clear_obs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   run_len;
    logic a, en;
    logic [DB_BITS-1:0] th;

    model_reset();
    clear_obs();
    @(negedge clk);

    // reset state
    do_reset(4'd3);
    check("reset_pulse",  int'(pulse_out),  0);
    check("reset_level",  int'(level_out),  0);
    check("reset_busy",   int'(busy),       0);
    check("reset_glitch", int'(glitch_cnt), 0);

    // clean rise: async high from edge 10, threshold 3
    do_reset(4'd3);
    for (int i = 1; i <= 9; i++)  cycle(1'b0, 1'b1, 4'd3, 1'b0);
    for (int i = 10; i <= 25; i++) cycle(1'b1, 1'b1, 4'd3, 1'b0);
    check("rise_pulse_edge",     dut_pulse_edge,  15);
    check("rise_model_edge",     mdl_pulse_edge,  15);
    check("rise_pulse_count",    dut_pulses,      1);
    check("rise_busy_cycles",    dut_busy_cycles, 3);
    check("rise_level",          int'(level_out), 1);

    // glitch rejection: 2 high samples against threshold 4
    do_reset(4'd4);
    for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 2; i++)  cycle(1'b1, 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4'd4, 1'b0);
    check("glitch_pulses", dut_pulses,       0);
    check("glitch_level",  int'(level_out),  0);
    check("glitch_count",  int'(glitch_cnt), 1);

    // zero threshold acts as one: pulse after edge 13 for a rise at edge 10
    do_reset(4'd0);
    for (int i = 1; i <= 9; i++)  cycle(1'b0, 1'b1, 4'd0, 1'b0);
    for (int i = 10; i <= 20; i++) cycle(1'b1, 1'b1, 4'd0, 1'b0);
    check("zero_thr_pulse_edge", dut_pulse_edge, 13);
    check("zero_thr_model_edge", mdl_pulse_edge, 13);

    // gating: enable low throughout a rise -> no pulse, level still rises
    do_reset(4'd1);
    for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 4'd1, 1'b0);
    check("gated_pulses", dut_pulses,      0);
    check("gated_level",  int'(level_out), 1);

    // rise then fall, threshold 2
    do_reset(4'd2);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b1, 4'd2, 1'b0);
    check("fall_pulses", dut_pulses,      BOTH ? 2 : 1);
    check("fall_level",  int'(level_out), 0);

    // reset while checking a rise
    do_reset(4'd5);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'd5, 1'b0);
    check("midchk_busy_before", int'(busy), 1);
    cycle(1'b1, 1'b1, 4'd5, 1'b1);
    check("midchk_busy",   int'(busy),       0);
    check("midchk_level",  int'(level_out),  0);
    check("midchk_pulse",  int'(pulse_out),  0);
    check("midchk_glitch", int'(glitch_cnt), 0);

    // saturation: 300 one-sample glitches
    do_reset(4'd2);
    for (int g = 0; g < 300; g++) begin
      cycle(1'b1, 1'b1, 4'd2, 1'b0);
      cycle(1'b0, 1'b1, 4'd2, 1'b0);
      cycle(1'b0, 1'b1, 4'd2, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'd2, 1'b0);
    check("sat_glitch",  int'(glitch_cnt), 255);
    check("sat_pulses",  dut_pulses,       0);

    // randomized run-length stimulus
    do_reset(4'd2);
    a  = 1'b0;
    th = 4'd2;
    for (int blk = 0; blk < 600; blk++) begin
      a = ~a;
      run_len = $urandom_range(1, 10);
      if ($urandom_range(0, 7) == 0) th = 4'($urandom_range(0, 7));
      for (int k = 0; k < run_len; k++) begin
        en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) th = 4'($urandom_range(0, 7));
        cycle(a, en, th, ($urandom_range(0, 299) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
